// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter that gives NUM_REQ requesters access to one combinational register-file read port.
// Latency: the response is valid 2 cycles after the request handshake; requests can issue at most once every 3 cycles.
// Backpressure: the response is held until the winner's rsp_ready is high; the optional REGFILE_ARB_RSP_TIMEOUT_EN build drops it after RSP_TIMEOUT cycles.
module regfile_read_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int RSP_TIMEOUT = 16
) (
    input  logic                          axis_aclk,
    input  logic                          axis_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic                          rf_read,
    output logic [ADDR_WIDTH-1:0]         rf_addr,
    input  logic [DATA_WIDTH-1:0]         rf_data,
    output logic                          rsp_drop
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || RSP_TIMEOUT < 1) begin : g_param_check
        $error("regfile_read_arbiter: NUM_REQ must be 2..8 and RSP_TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        ptr;
    logic [IDX_W-1:0]        win;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    grant_found;
    logic [IDX_W-1:0]        grant_idx;
    logic [ADDR_WIDTH-1:0]   grant_addr;
    logic                    req_fire;
    logic                    rsp_fire;
    logic                    timeout_hit;

    // Search starts at ptr and wraps; the first active requester wins.
    always_comb begin : arb
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_addr  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(idx);
                grant_addr  = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign req_fire = (state == IDLE) && grant_found && !axis_rst;
    assign rsp_fire = (state == RESP) && rsp_ready[win];

    always_comb begin
        req_ready = '0;
        if (req_fire) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = (state == RESP) && (win == IDX_W'(i));
        end
    end

    assign rf_read = (state == ISSUE);
    assign rf_addr = rf_read ? addr_q : '0;

`ifdef REGFILE_ARB_RSP_TIMEOUT_EN
    localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);

    logic [CNT_W-1:0] to_cnt;

    // The count is the number of completed RESP cycles; it expires on the RSP_TIMEOUT-th.
    assign timeout_hit = (state == RESP) && !rsp_ready[win] &&
                         (to_cnt == CNT_W'(RSP_TIMEOUT - 1));

    always_ff @(posedge axis_aclk) begin
        if (axis_rst) begin
            to_cnt   <= '0;
            rsp_drop <= 1'b0;
        end else begin
            rsp_drop <= timeout_hit;
            if (state != RESP) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_drop    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_fire) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    if (rsp_fire || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_rst) begin
            state    <= IDLE;
            ptr      <= '0;
            win      <= '0;
            addr_q   <= '0;
            rsp_data <= '0;
        end else begin
            state <= state_nxt;
            if (req_fire) begin
                win    <= grant_idx;
                addr_q <= grant_addr;
                ptr    <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (state == ISSUE) begin
                rsp_data <= rf_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter: per-cycle vector table plus latency and hold/timeout sequences.
module tb_regfile_read_arbiter;

    localparam logic [31:0] D0 = 32'hA5A5_0001;
    localparam logic [31:0] D1 = 32'hC0DE_0120;
    localparam logic [31:0] D2 = 32'hC0DE_0230;
    localparam logic [31:0] D3 = 32'hC0DE_0340;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [47:0] req_addr;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_ready = '0;
    logic        rf_read;
    logic [11:0] rf_addr;
    logic [31:0] rf_data;
    logic        rsp_drop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_read_arbiter #(
        .NUM_REQ(4), .ADDR_WIDTH(12), .DATA_WIDTH(32), .RSP_TIMEOUT(16)
    ) dut (
        .axis_aclk(clk),
        .axis_rst (rst),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_ready(rsp_ready),
        .rf_read  (rf_read),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .rsp_drop (rsp_drop)
    );

    function automatic logic [31:0] mem(input logic [11:0] a);
        if (a == 12'h010) return D0;
        return {20'hC0DE0, a};
    endfunction

    always_comb rf_data = rf_read ? mem(rf_addr) : '0;
    assign req_addr = {12'h340, 12'h230, 12'h120, 12'h010};

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic [3:0]  rdy;
        logic [3:0]  e_ready;
        logic        e_rd;
        logic [11:0] e_addr;
        logic [3:0]  e_vld;
        logic [31:0] e_data;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] rv, input logic [3:0] rdy,
                       input logic [3:0] er, input logic rd, input logic [11:0] ea,
                       input logic [3:0] ev, input logic [31:0] ed);
        vec_t v;
        v.rst = r; v.rv = rv; v.rdy = rdy; v.e_ready = er;
        v.e_rd = rd; v.e_addr = ea; v.e_vld = ev; v.e_data = ed;
        vq.push_back(v);
    endtask

    initial begin
        int n;
        int k;

        // single request from requester 0 (ptr 0)
        add(0, 4'b0001, 4'b1111, 4'b0001, 0, 12'h000, 4'b0000, 32'h0);
        add(0, 4'b0000, 4'b1111, 4'b0000, 1, 12'h010, 4'b0000, 32'h0);
        add(0, 4'b0000, 4'b1111, 4'b0000, 0, 12'h000, 4'b0001, D0);
        add(0, 4'b0000, 4'b1111, 4'b0000, 0, 12'h000, 4'b0000, D0);
        // lone requester 0 still wins with ptr at 1
        add(0, 4'b0001, 4'b1111, 4'b0001, 0, 12'h000, 4'b0000, D0);
        add(0, 4'b0000, 4'b1111, 4'b0000, 1, 12'h010, 4'b0000, D0);
        add(0, 4'b0000, 4'b1111, 4'b0000, 0, 12'h000, 4'b0001, D0);
        // reset in IDLE holds req_ready low, then full contention from ptr 0
        add(1, 4'b1111, 4'b1111, 4'b0000, 0, 12'h000, 4'b0000, D0);
        add(0, 4'b1111, 4'b1111, 4'b0001, 0, 12'h000, 4'b0000, 32'h0);
        add(0, 4'b1111, 4'b1111, 4'b0000, 1, 12'h010, 4'b0000, 32'h0);
        add(0, 4'b1111, 4'b1111, 4'b0000, 0, 12'h000, 4'b0001, D0);
        add(0, 4'b1111, 4'b1111, 4'b0010, 0, 12'h000, 4'b0000, D0);
        add(0, 4'b1111, 4'b1111, 4'b0000, 1, 12'h120, 4'b0000, D0);
        add(0, 4'b1111, 4'b1111, 4'b0000, 0, 12'h000, 4'b0010, D1);
        add(0, 4'b1111, 4'b1111, 4'b0100, 0, 12'h000, 4'b0000, D1);
        add(0, 4'b1111, 4'b1111, 4'b0000, 1, 12'h230, 4'b0000, D1);
        add(0, 4'b1111, 4'b1111, 4'b0000, 0, 12'h000, 4'b0100, D2);
        add(0, 4'b1111, 4'b1111, 4'b1000, 0, 12'h000, 4'b0000, D2);
        add(0, 4'b1111, 4'b1111, 4'b0000, 1, 12'h340, 4'b0000, D2);
        add(0, 4'b1111, 4'b1111, 4'b0000, 0, 12'h000, 4'b1000, D3);
        add(0, 4'b1111, 4'b1111, 4'b0001, 0, 12'h000, 4'b0000, D3);
        add(0, 4'b1111, 4'b1111, 4'b0000, 1, 12'h010, 4'b0000, D3);
        // backpressure: five cycles without the winner's rsp_ready; other ready bits ignored
        add(0, 4'b1111, 4'b1110, 4'b0000, 0, 12'h000, 4'b0001, D0);
        for (int i = 0; i < 4; i++)
            add(0, 4'b1111, 4'b0000, 4'b0000, 0, 12'h000, 4'b0001, D0);
        add(0, 4'b1111, 4'b0001, 4'b0000, 0, 12'h000, 4'b0001, D0);
        add(0, 4'b1111, 4'b1111, 4'b0010, 0, 12'h000, 4'b0000, D0);
        // reset during ISSUE abandons the read; the first grant afterwards is requester 0
        add(1, 4'b1111, 4'b1111, 4'b0000, 1, 12'h120, 4'b0000, D0);
        add(0, 4'b0000, 4'b1111, 4'b0000, 0, 12'h000, 4'b0000, 32'h0);
        add(0, 4'b0000, 4'b1111, 4'b0000, 0, 12'h000, 4'b0000, 32'h0);
        add(0, 4'b1111, 4'b1111, 4'b0001, 0, 12'h000, 4'b0000, 32'h0);
        add(0, 4'b0000, 4'b1111, 4'b0000, 1, 12'h010, 4'b0000, 32'h0);
        // requester 2 asserts only while busy, then withdraws: never served
        add(0, 4'b0100, 4'b1111, 4'b0000, 0, 12'h000, 4'b0001, D0);
        add(0, 4'b0000, 4'b1111, 4'b0000, 0, 12'h000, 4'b0000, D0);
        add(0, 4'b0000, 4'b1111, 4'b0000, 0, 12'h000, 4'b0000, D0);

        rst = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 4'b0000;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_data", rsp_data, 32'h0);
        chk("reset_rf_read", 32'(rf_read), 32'h0);
        chk("reset_rf_addr", 32'(rf_addr), 32'h0);
        chk("reset_rsp_drop", 32'(rsp_drop), 32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst       = vq[i].rst;
            req_valid = vq[i].rv;
            rsp_ready = vq[i].rdy;
            #1;
            chk($sformatf("row%0d_req_ready", i), 32'(req_ready), 32'(vq[i].e_ready));
            chk($sformatf("row%0d_rf_read", i), 32'(rf_read), 32'(vq[i].e_rd));
            chk($sformatf("row%0d_rf_addr", i), 32'(rf_addr), 32'(vq[i].e_addr));
            chk($sformatf("row%0d_rsp_valid", i), 32'(rsp_valid), 32'(vq[i].e_vld));
            chk($sformatf("row%0d_rsp_data", i), rsp_data, vq[i].e_data);
            chk($sformatf("row%0d_rsp_drop", i), 32'(rsp_drop), 32'h0);
        end

        // latency from handshake to response for requester 3 (ptr is 1 here)
        @(negedge clk);
        req_valid = 4'b1000;
        rsp_ready = 4'b0000;
        #1;
        chk("lat_grant", 32'(req_ready), 32'h8);
        n = 0;
        do begin
            @(negedge clk);
            req_valid = 4'b0000;
            #1;
            n++;
        end while (rsp_valid == 4'b0000 && n < 10);
        chk("lat_cycles", 32'(n), 32'd2);
        chk("lat_rsp_valid", 32'(rsp_valid), 32'h8);
        chk("lat_rsp_data", rsp_data, D3);

`ifdef REGFILE_ARB_RSP_TIMEOUT_EN
        k = 1;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            #1;
            n++;
            if (rsp_drop) break;
            if (rsp_valid == 4'b1000) k++;
        end
        chk("to_drop_seen", 32'(rsp_drop), 32'h1);
        chk("to_resp_cycles", 32'(k), 32'd16);
        chk("to_rsp_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        #1;
        chk("to_drop_pulse", 32'(rsp_drop), 32'h0);
        chk("to_idle_rf_read", 32'(rf_read), 32'h0);
`else
        k = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (rsp_valid == 4'b1000 && rsp_data == D3) k++;
        end
        chk("hold_cycles", 32'(k), 32'd20);
        chk("hold_rsp_drop", 32'(rsp_drop), 32'h0);
        @(negedge clk);
        rsp_ready = 4'b1000;
        #1;
        chk("hold_release_vld", 32'(rsp_valid), 32'h8);
        @(negedge clk);
        rsp_ready = 4'b0000;
        #1;
        chk("hold_after_vld", 32'(rsp_valid), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_read_arbiter.md
REGFILE_READ_ARBITER -- requirements
Module: regfile_read_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of internal read requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, register file address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, register file data width.
REQ-004 SHALL have parameter RSP_TIMEOUT, default 16, number of response-hold cycles before a drop (used only with the timeout macro).
REQ-005 SHALL have port axis_aclk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port axis_rst, input, 1 bit, synchronous, active-high reset.
REQ-007 SHALL have port req_valid, input, NUM_REQ bits, per-requester read request.
REQ-008 SHALL have port req_addr, input, NUM_REQ*ADDR_WIDTH bits, packed addresses; requester i occupies slice i.
REQ-009 SHALL have port req_ready, output, NUM_REQ bits, one-hot request accept.
REQ-010 SHALL have port rsp_valid, output, NUM_REQ bits, one-hot response valid.
REQ-011 SHALL have port rsp_data, output, DATA_WIDTH bits, response data shared by all requesters.
REQ-012 SHALL have port rsp_ready, input, NUM_REQ bits, per-requester response accept.
REQ-013 SHALL have port rf_read, output, 1 bit, drives the register file internal read enable.
REQ-014 SHALL have port rf_addr, output, ADDR_WIDTH bits, drives the register file internal read address.
REQ-015 SHALL have port rf_data, input, DATA_WIDTH bits, the register file internal read data (combinational, zero when rf_read is low).
REQ-016 SHALL have port rsp_drop, output, 1 bit, one-cycle pulse on a timeout drop (tied 0 without the macro).

Function
REQ-017 SHALL implement a three-state FSM: IDLE, ISSUE, RESP.
REQ-018 In IDLE with any req_valid high, SHALL assert req_ready combinationally for exactly one winner, chosen round-robin starting at pointer ptr.
REQ-019 On the IDLE req handshake, SHALL latch the winner index and req_addr slice, set ptr to (winner+1) mod NUM_REQ, and move to ISSUE.
REQ-020 In ISSUE, SHALL drive rf_read=1 and rf_addr=the latched address for exactly one cycle, register rf_data into rsp_data, and move to RESP.
REQ-021 In RESP, SHALL hold rsp_valid[winner]=1 and rsp_data stable until rsp_ready[winner] is high, then return to IDLE.
REQ-022 SHALL keep req_ready all-zero outside IDLE; request-to-response latency is 2 cycles and minimum issue interval is 3 cycles.
REQ-023 SHALL ignore rsp_ready bits of non-winning requesters.
REQ-024 SHALL keep rf_read=0 and rf_addr=0 in every state other than ISSUE.
REQ-025 A requester that drops req_valid before its handshake SHALL NOT be granted, and no response SHALL be issued for it.
REQ-026 When only one requester is active, SHALL grant it on every IDLE visit regardless of ptr.

Reset
REQ-027 When axis_rst=1, on the next clock edge SHALL enter IDLE, set ptr=0, and set rsp_data=0, rsp_valid=0, rsp_drop=0, rf_read=0, rf_addr=0, and the timeout counter to 0.
REQ-028 While axis_rst=1, SHALL hold req_ready=0.
REQ-029 A reset asserted mid-transaction SHALL abandon the transaction with no response delivered after reset deasserts.

Configuration
REQ-030 When REGFILE_ARB_RSP_TIMEOUT_EN is defined, a counter SHALL run in RESP. If RSP_TIMEOUT cycles elapse without rsp_ready[winner], the block SHALL drop the response, pulse rsp_drop for 1 cycle, and return to IDLE.
REQ-031 When REGFILE_ARB_RSP_TIMEOUT_EN is undefined, SHALL wait in RESP indefinitely and tie rsp_drop to 0.

Verification
REQ-032 Single request: req_valid=4'b0001, addr0=0x010, register file holds 0xA5A5_0001 there, rsp_ready=1 -> rf_read pulses 1 cycle after the handshake; rsp_valid=4'b0001 with rsp_data=0xA5A5_0001 2 cycles after the handshake.
REQ-033 Contention: req_valid=4'b1111 held, ptr=0 -> grant order 0,1,2,3,0, with each grant 3 cycles apart.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stay stable, req_ready stays 0, and the next grant follows rsp_ready=1.
REQ-035 Reset during ISSUE -> no rsp_valid is delivered, and the first grant after reset goes to requester 0.
REQ-036 With REGFILE_ARB_RSP_TIMEOUT_EN and RSP_TIMEOUT=16, rsp_ready held 0 -> rsp_drop pulses once 16 cycles into RESP, rsp_valid falls, and the FSM returns to IDLE.
